// File: rtl/alu_issue.sv
// alu_issue: two-entry in-order operand buffer between register read and the ALU.
// Define ALU_ISSUE_FORWARD_EN to snoop the writeback bus into captured and resident operands.
`ifndef WIDTH
`define WIDTH 32
`endif

module alu_issue (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_opcode,
   input  logic [4:0]        in_ra,
   input  logic [4:0]        in_rb,
   input  logic [`WIDTH-1:0] in_a,
   input  logic [`WIDTH-1:0] in_b,
   input  logic [4:0]        in_rd,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [`WIDTH-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_opcode,
   output logic [`WIDTH-1:0] out_a,
   output logic [`WIDTH-1:0] out_b,
   output logic [4:0]        out_rd
);

   localparam int unsigned W = `WIDTH;

   typedef enum logic [1:0] {
      st_empty = 2'd0,
      st_one   = 2'd1,
      st_full  = 2'd2
   } state_t;

   state_t        state_q;
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [4:0]    op_q [2];
   logic [W-1:0]  a_q  [2];
   logic [W-1:0]  b_q  [2];
   logic [4:0]    rd_q [2];

   logic          push;
   logic          pop;
   logic [W-1:0]  cap_a;
   logic [W-1:0]  cap_b;

   // Handshakes depend only on registered occupancy; rst forces in_ready low while held.
   assign out_valid = (state_q != st_empty);
   assign in_ready  = !rst && (state_q != st_full);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef ALU_ISSUE_FORWARD_EN
   logic [4:0]    ra_q [2];
   logic [4:0]    rb_q [2];
   logic [1:0]    live;
   logic          wb_live;

   assign wb_live = wb_valid && (wb_rd != 5'd0);
   assign cap_a   = (wb_live && (wb_rd == in_ra)) ? wb_data : in_a;
   assign cap_b   = (wb_live && (wb_rd == in_rb)) ? wb_data : in_b;

   always_comb begin
      live = 2'b00;
      case (state_q)
         st_one:  live[rd_ptr_q] = 1'b1;
         st_full: live = 2'b11;
         default: live = 2'b00;
      endcase
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_rd, wb_data, in_ra, in_rb};
   assign cap_a     = in_a;
   assign cap_b     = in_b;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= st_empty;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            op_q[i] <= '0;
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            rd_q[i] <= '0;
`ifdef ALU_ISSUE_FORWARD_EN
            ra_q[i] <= '0;
            rb_q[i] <= '0;
`endif
         end
      end else begin
         case (state_q)
            st_empty: if (push) state_q <= st_one;
            st_one: begin
               if (push && !pop)      state_q <= st_full;
               else if (pop && !push) state_q <= st_empty;
            end
            st_full:  if (pop) state_q <= st_one;
            default:  state_q <= st_empty;
         endcase

`ifdef ALU_ISSUE_FORWARD_EN
         // The entry leaving this cycle has already been consumed; skip its update.
         for (int i = 0; i < 2; i++) begin
            if (live[i] && !(pop && (rd_ptr_q == 1'(i))) && wb_live) begin
               if (ra_q[i] == wb_rd) a_q[i] <= wb_data;
               if (rb_q[i] == wb_rd) b_q[i] <= wb_data;
            end
         end
`endif

         if (push) begin
            op_q[wr_ptr_q] <= in_opcode;
            a_q[wr_ptr_q]  <= cap_a;
            b_q[wr_ptr_q]  <= cap_b;
            rd_q[wr_ptr_q] <= in_rd;
`ifdef ALU_ISSUE_FORWARD_EN
            ra_q[wr_ptr_q] <= in_ra;
            rb_q[wr_ptr_q] <= in_rb;
`endif
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign out_opcode = out_valid ? op_q[rd_ptr_q] : '0;
   assign out_a      = out_valid ? a_q[rd_ptr_q]  : '0;
   assign out_b      = out_valid ? b_q[rd_ptr_q]  : '0;
   assign out_rd     = out_valid ? rd_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: queue-model scoreboard plus directed vectors for alu_issue.
`ifndef WIDTH
`define WIDTH 32
`endif

module tb_alu_issue;

   localparam int W = `WIDTH;
`ifdef ALU_ISSUE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   in_opcode, in_ra, in_rb, in_rd;
   logic [W-1:0] in_a, in_b;
   logic         wb_valid;
   logic [4:0]   wb_rd;
   logic [W-1:0] wb_data;
   logic         out_valid;
   logic         out_ready;
   logic [4:0]   out_opcode, out_rd;
   logic [W-1:0] out_a, out_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]   op;
      logic [4:0]   ra;
      logic [4:0]   rb;
      logic [4:0]   rd;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } ent_t;

   ent_t q[$];
   ent_t e_new;
   bit   m_push, m_pop;

   alu_issue dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_ra      (in_ra),
      .in_rb      (in_rb),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_rd      (in_rd),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of at most two entries with writeback snooping.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
      end else begin
         m_push = in_valid && (q.size() < 2);
         m_pop  = out_ready && (q.size() > 0);
         if (FWD && wb_valid && wb_rd != 5'd0) begin
            for (int j = (m_pop ? 1 : 0); j < q.size(); j++) begin
               if (q[j].ra == wb_rd) q[j].a = wb_data;
               if (q[j].rb == wb_rd) q[j].b = wb_data;
            end
         end
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            e_new.op = in_opcode;
            e_new.ra = in_ra;
            e_new.rb = in_rb;
            e_new.rd = in_rd;
            e_new.a  = (FWD && wb_valid && wb_rd != 5'd0 && wb_rd == in_ra) ? wb_data : in_a;
            e_new.b  = (FWD && wb_valid && wb_rd != 5'd0 && wb_rd == in_rb) ? wb_data : in_b;
            q.push_back(e_new);
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", W'(in_ready), W'(!rst && q.size() < 2));
      chk("out_valid", W'(out_valid), W'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_opcode", W'(out_opcode), W'(q[0].op));
         chk("out_a", out_a, q[0].a);
         chk("out_b", out_b, q[0].b);
         chk("out_rd", W'(out_rd), W'(q[0].rd));
      end else begin
         chk("out_opcode idle", W'(out_opcode), '0);
         chk("out_a idle", out_a, '0);
         chk("out_b idle", out_b, '0);
         chk("out_rd idle", W'(out_rd), '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] op, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
      in_valid  = 1'b1;
      in_opcode = op;
      in_ra     = ra;
      in_rb     = rb;
      in_a      = a;
      in_b      = b;
      in_rd     = rd;
   endtask

   logic [W-1:0] exp_v;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_ra = '0; in_rb = '0; in_rd = '0;
      in_a = '0; in_b = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
      #1;
      chk("reset in_ready", W'(in_ready), '0);
      chk("reset out_valid", W'(out_valid), '0);
      chk("reset out_a", out_a, '0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("in_ready after reset", W'(in_ready), 1);

      // Single op, one cycle latency
      out_ready = 1'b1;
      set_in(5'd0, 5'd1, 5'd2, 3, 4, 5'd5);
      tick();
      in_valid = 1'b0;
      chk("lat out_valid", W'(out_valid), 1);
      chk("lat out_a", out_a, 3);
      chk("lat out_b", out_b, 4);
      chk("lat out_rd", W'(out_rd), 5);
      tick();
      chk("lat drained", W'(out_valid), 0);

      // Back-pressure and in-order drain
      out_ready = 1'b0;
      set_in(5'd1, 5'd1, 5'd2, 32'h11, 32'h1, 5'd1);
      tick();
      chk("bp in_ready one", W'(in_ready), 1);
      set_in(5'd2, 5'd1, 5'd2, 32'h22, 32'h2, 5'd2);
      tick();
      chk("bp in_ready full", W'(in_ready), 0);
      set_in(5'd3, 5'd1, 5'd2, 32'h33, 32'h3, 5'd3);
      tick(); tick();
      chk("bp head held", out_a, 32'h11);
      chk("bp still full", W'(in_ready), 0);
      out_ready = 1'b1;
      tick();
      chk("drain op2", out_a, 32'h22);
      tick();
      in_valid = 1'b0;
      chk("drain op3", out_a, 32'h33);
      tick();
      chk("drain empty", W'(out_valid), 0);

      // Capture-time forwarding
      out_ready = 1'b0;
      set_in(5'd0, 5'd7, 5'd9, 32'h1, 32'h2, 5'd3);
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
`ifdef ALU_ISSUE_FORWARD_EN
      exp_v = 32'hDEAD;
`else
      exp_v = 32'h1;
`endif
      tick();
      in_valid = 1'b0; wb_valid = 1'b0;
      chk("capture fwd a", out_a, exp_v);
      chk("capture b", out_b, 32'h2);

      // Resident forwarding
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
`ifdef ALU_ISSUE_FORWARD_EN
      exp_v = 32'h55;
`else
      exp_v = 32'h2;
`endif
      tick();
      wb_valid = 1'b0;
      chk("resident fwd b", out_b, exp_v);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fwd drained", W'(out_valid), 0);

      // Index 0 is never forwarded
      set_in(5'd4, 5'd0, 5'd0, 32'h10, 32'h2, 5'd4);
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
      tick();
      in_valid = 1'b0;
      chk("r0 capture a", out_a, 32'h10);
      tick();
      wb_valid = 1'b0;
      chk("r0 resident b", out_b, 32'h2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Pop colliding with a writeback; unknown opcode passthrough
      set_in(5'h1f, 5'd3, 5'd4, 32'h30, 32'h5, 5'd6);
      tick();
      chk("opcode passthrough", W'(out_opcode), 32'h1f);
      set_in(5'd2, 5'd3, 5'd8, 32'h40, 32'h6, 5'd7);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
      #1;
      chk("pop pre-update", out_a, 32'h30);
`ifdef ALU_ISSUE_FORWARD_EN
      exp_v = 32'h99;
`else
      exp_v = 32'h40;
`endif
      tick();
      wb_valid = 1'b0;
      chk("second entry fwd", out_a, exp_v);
      tick();
      chk("collision drained", W'(out_valid), 0);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      set_in(5'd1, 5'd1, 5'd1, 32'hA, 32'hB, 5'd1);
      tick();
      set_in(5'd2, 5'd2, 5'd2, 32'hC, 32'hD, 5'd2);
      tick();
      in_valid = 1'b0;
      chk("full before rst", W'(in_ready), 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", W'(out_valid), 0);
      chk("async rst out_a", out_a, '0);
      chk("async rst out_opcode", W'(out_opcode), '0);
      chk("async rst in_ready", W'(in_ready), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("post rst in_ready", W'(in_ready), 1);
      out_ready = 1'b1;
      tick();
      chk("no stale entry", W'(out_valid), 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
